// File: rtl/mem_1_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_1_arbiter_if
//  Description : Avalon-MM-style requester port used by each master of the
//                mem_1 arbiter (command, back-pressure and read return).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_1_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    // Requester side: issues commands, receives back-pressure and read data
    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    // Arbiter side: accepts commands, drives back-pressure and read data
    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/mem_1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_1_arbiter
//  Description : Two-master round-robin arbiter and power-up zero-fill
//                initializer for the single-port on-chip memory mem_1.
//                Read data returns after a fixed latency, tagged with the
//                issuing master.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_1_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire                   clk,
    input  wire                   reset_n,
    mem_1_arbiter_if.slave        a,
    mem_1_arbiter_if.slave        b,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  wire  [DATA_W-1:0]     mem_readdata,
    output logic                  init_done
);

    localparam int                BE_W        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_clear_cnt;
    logic                    r_init_done;
    logic                    r_last_grant_b;   // 1 = B was granted most recently
    logic [READ_LATENCY-1:0] r_tag_valid;
    logic [READ_LATENCY-1:0] r_tag_owner_b;

    logic w_ready;
    logic w_req_a;
    logic w_req_b;
    logic w_grant_a;
    logic w_grant_b;
    logic w_rd_accept;

    assign w_ready = (r_state == ST_READY);
    assign w_req_a = a.read | a.write;
    assign w_req_b = b.read | b.write;

    // A lone requester always wins; on a tie the master not served last wins
    assign w_grant_a = w_ready & w_req_a & (~w_req_b |  r_last_grant_b);
    assign w_grant_b = w_ready & w_req_b & (~w_req_a | ~r_last_grant_b);

    assign w_rd_accept = (w_grant_a & a.read) | (w_grant_b & b.read);

    // Idle masters in READY see no back-pressure; during CLEAR everyone waits
    assign a.waitrequest = ~w_ready | (w_req_a & ~w_grant_a);
    assign b.waitrequest = ~w_ready | (w_req_b & ~w_grant_b);

    // The memory output register is shared; the valid strobe picks the owner
    assign a.readdata      = mem_readdata;
    assign b.readdata      = mem_readdata;
    assign a.readdatavalid = r_tag_valid[READ_LATENCY-1] & ~r_tag_owner_b[READ_LATENCY-1];
    assign b.readdatavalid = r_tag_valid[READ_LATENCY-1] &  r_tag_owner_b[READ_LATENCY-1];

    // Memory command mux: zero-fill writes during CLEAR, granted master otherwise
    always_comb begin
        mem_address    = r_clear_cnt;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_writedata  = '0;
        mem_byteenable = '1;
        if (w_ready) begin
            mem_address    = w_grant_a ? a.address    : b.address;
            mem_writedata  = w_grant_a ? a.writedata  : b.writedata;
            mem_byteenable = w_grant_a ? a.byteenable : b.byteenable;
            mem_chipselect = w_grant_a | w_grant_b;
            mem_write      = (w_grant_a & a.write) | (w_grant_b & b.write);
        end
    end

    assign mem_clken = 1'b1;
    assign init_done = r_init_done;

    // Control FSM: zero-fill sequencing, init flag and round-robin history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_reset_state;
            r_clear_cnt    <= '0;
            r_init_done    <= (CLEAR_ON_RESET == 0);
            r_last_grant_b <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clear_cnt <= r_clear_cnt + ADDR_W'(1);
                    if (r_clear_cnt == c_last_addr) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_grant_a) begin
                        r_last_grant_b <= 1'b0;
                    end else if (w_grant_b) begin
                        r_last_grant_b <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_reset_state;
                end
            endcase
        end
    end

    // Read tag pipeline matching the memory latency; reset discards tags in flight
    if (READ_LATENCY > 1) begin : g_tag_multi
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_tag_valid   <= '0;
                r_tag_owner_b <= '0;
            end else begin
                r_tag_valid   <= {r_tag_valid[READ_LATENCY-2:0],   w_rd_accept};
                r_tag_owner_b <= {r_tag_owner_b[READ_LATENCY-2:0], w_grant_b};
            end
        end
    end else begin : g_tag_single
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_tag_valid   <= '0;
                r_tag_owner_b <= '0;
            end else begin
                r_tag_valid   <= w_rd_accept;
                r_tag_owner_b <= w_grant_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_1_arbiter
//  Description : Self-checking bench for mem_1_arbiter with a behavioural
//                mem_1 model and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_1_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int LAT    = 1;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_readdata;
    logic              init_done;

    mem_1_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    mem_1_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

    mem_1_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .a(a_if), .b(b_if),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .init_done(init_done)
    );

    // Behavioural mem_1: byte-masked writes, registered reads of depth LAT
    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int i = 0; i < BE_W; i++)
                    if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end else begin
                rd_pipe[0] <= ram[mem_address];
            end
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_readdata = rd_pipe[LAT-1];

    // Reference model state
    typedef struct packed {
        bit              v;
        bit              wr;
        logic [9:0]      addr;
        logic [31:0]     data;
        logic [3:0]      be;
    } cmd_t;

    typedef struct {
        int          due;
        bit          owner_b;
        logic [31:0] data;
    } rd_t;

    logic [31:0] ref_mem [DEPTH];
    rd_t         exp_q[$];
    bit          exp_last_b;
    cmd_t        ca, cb;
    int          cyc;
    int          acc_a, acc_b;
    logic [31:0] got_a, got_b;
    int          tests, fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input bit wr, input int addr, input logic [31:0] data, input logic [3:0] be);
        cmd_t c;
        c.v    = 1'b1;
        c.wr   = wr;
        c.addr = addr[9:0];
        c.data = data;
        c.be   = be;
        return c;
    endfunction

    function automatic cmd_t rd(input int addr);
        return mk(1'b0, addr, 32'h0, 4'hF);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    task automatic drive();
        a_if.address    = ca.addr;  a_if.writedata = ca.data;  a_if.byteenable = ca.be;
        a_if.read       = ca.v && !ca.wr;
        a_if.write      = ca.v &&  ca.wr;
        b_if.address    = cb.addr;  b_if.writedata = cb.data;  b_if.byteenable = cb.be;
        b_if.read       = cb.v && !cb.wr;
        b_if.write      = cb.v &&  cb.wr;
    endtask

    task automatic apply(input cmd_t c, input bit owner_b);
        rd_t r;
        if (c.wr) begin
            ref_mem[c.addr] = merge(ref_mem[c.addr], c.data, c.be);
        end else begin
            r.due     = cyc + LAT;
            r.owner_b = owner_b;
            r.data    = ref_mem[c.addr];
            exp_q.push_back(r);
        end
    endtask

    // One READY-mode clock cycle: drive, check at negedge, advance model
    task automatic step();
        bit          ga, gb, ev_a, ev_b;
        logic [31:0] ed;
        cmd_t        g;
        drive();
        @(negedge clk);
        ga = ca.v && (!cb.v ||  exp_last_b);
        gb = cb.v && (!ca.v || !exp_last_b);
        if (ca.v) chk("a_waitrequest", a_if.waitrequest, !ga);
        if (cb.v) chk("b_waitrequest", b_if.waitrequest, !gb);
        chk("mem_chipselect", mem_chipselect, ga || gb);
        chk("mem_clken", mem_clken, 1'b1);
        if (ga || gb) begin
            g = ga ? ca : cb;
            chk("mem_address", mem_address, g.addr);
            chk("mem_write", mem_write, g.wr);
        end
        ev_a = 1'b0; ev_b = 1'b0; ed = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev_a = !exp_q[0].owner_b;
            ev_b =  exp_q[0].owner_b;
            ed   =  exp_q[0].data;
            exp_q.delete(0);
        end
        chk("a_readdatavalid", a_if.readdatavalid, ev_a);
        chk("b_readdatavalid", b_if.readdatavalid, ev_b);
        if (ev_a) begin chk("a_readdata", a_if.readdata, ed); got_a = a_if.readdata; end
        if (ev_b) begin chk("b_readdata", b_if.readdata, ed); got_b = b_if.readdata; end
        if (ga) begin
            acc_a++; exp_last_b = 1'b0; apply(ca, 1'b0); ca.v = 1'b0;
        end else if (gb) begin
            acc_b++; exp_last_b = 1'b1; apply(cb, 1'b1); cb.v = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((ca.v || cb.v) && n < max) begin
            step();
            n++;
        end
        chk("accept_timeout", ca.v || cb.v, 1'b0);
    endtask

    task automatic drain();
        repeat (LAT + 1) step();
        chk("reads_outstanding", exp_q.size(), 0);
    endtask

    task automatic single(input bit on_b, input cmd_t c);
        if (on_b) cb = c; else ca = c;
        run_until_idle(20);
        drain();
    endtask

    // Zero-fill phase: counts cycles until init_done or until stop_at
    task automatic clear_phase(input int stop_at, output int n);
        n = 0;
        while (init_done !== 1'b1 && n < stop_at) begin
            @(negedge clk);
            if (n == 0 || n == 299 || n == 511 || n == 1023) begin
                chk("clear_mem_address", mem_address, n[ADDR_W-1:0]);
                chk("clear_mem_cmd", {mem_chipselect, mem_write, mem_byteenable, mem_writedata}, {6'b111111, 32'h0});
                chk("clear_waitrequest", {a_if.waitrequest, b_if.waitrequest}, 2'b11);
                chk("clear_readdatavalid", {a_if.readdatavalid, b_if.readdatavalid}, 2'b00);
                chk("clear_init_done", init_done, 1'b0);
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_last_b = 1'b1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ai;
        tests = 0; fails = 0; cyc = 0; acc_a = 0; acc_b = 0;
        got_a = 32'hFFFF_FFFF; got_b = 32'hFFFF_FFFF;
        ca = '0; cb = '0;
        reset_model();
        reset_n = 1'b0;
        drive();

        // Reset values
        repeat (3) begin
            @(negedge clk);
            chk("rst_init_done", init_done, 1'b0);
            chk("rst_readdatavalid", {a_if.readdatavalid, b_if.readdatavalid}, 2'b00);
            chk("rst_mem_cs_wr", {mem_chipselect, mem_write}, 2'b11);
        end
        @(posedge clk); #1;

        // Clear with both masters already requesting; A must win the first tie
        ca = rd(7); cb = rd(9); drive();
        reset_n = 1'b1;
        clear_phase(2000, n);
        chk("clear_cycles", n, 1024);
        zero_model();
        run_until_idle(10);
        drain();
        chk("clear_read_a7", got_a, 32'h0);
        chk("clear_read_b9", got_b, 32'h0);
        foreach (ref_mem[i]) if (i == 0 || i == 511 || i == 1023) begin
            got_a = 32'hFFFF_FFFF;
            single(1'b0, rd(i));
            chk("clear_readback", got_a, 32'h0);
        end

        // Single master write then read
        single(1'b0, mk(1'b1, 5, 32'hDEADBEEF, 4'hF));
        got_a = 32'h0;
        single(1'b0, rd(5));
        chk("single_read", got_a, 32'hDEADBEEF);

        // Byte enables
        single(1'b0, mk(1'b1, 20, 32'h11223344, 4'hF));
        single(1'b0, mk(1'b1, 20, 32'hAABBCCDD, 4'b0101));
        got_b = 32'h0;
        single(1'b1, rd(20));
        chk("byteenable_read", got_b, 32'h11BB33DD);

        // Contention: both request every cycle for 8 cycles
        acc_a = 0; acc_b = 0;
        for (int i = 0; i < 8; i++) begin
            if (!ca.v) ca = mk(1'b1, 40 + i, $urandom, 4'hF);
            if (!cb.v) cb = mk(1'b1, 60 + i, $urandom, 4'hF);
            step();
        end
        chk("contention_acc_a", acc_a, 4);
        chk("contention_acc_b", acc_b, 4);
        run_until_idle(10);
        drain();

        // Back-to-back interleaved reads: A reads 1,2,3; B reads 4
        for (int i = 1; i <= 4; i++) single(1'b0, mk(1'b1, i, 32'h1000_0000 * i + i, 4'hF));
        ai = 1; ca = rd(1); cb = rd(4);
        for (int i = 0; i < 10; i++) begin
            if (ca.v || cb.v) begin
                step();
                if (!ca.v && ai < 3) begin ai++; ca = rd(ai); end
            end
        end
        chk("b2b_all_accepted", ca.v || cb.v, 1'b0);
        drain();
        chk("b2b_last_a", got_a, 32'h3000_0003);
        chk("b2b_last_b", got_b, 32'h4000_0004);

        // Reset with a read in flight, then reset again mid-clear
        ca = rd(5);
        step();
        reset_n = 1'b0;
        reset_model();
        ca = '0; cb = '0; drive();
        repeat (2) begin
            @(negedge clk);
            chk("flush_readdatavalid", {a_if.readdatavalid, b_if.readdatavalid}, 2'b00);
            chk("flush_init_done", init_done, 1'b0);
        end
        @(posedge clk); #1;
        ca = rd(7); cb = rd(9); drive();
        reset_n = 1'b1;
        clear_phase(300, n);
        chk("midclear_address", mem_address, 10'd300);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midclear_rst_readdatavalid", {a_if.readdatavalid, b_if.readdatavalid}, 2'b00);
        chk("midclear_rst_address", mem_address, 10'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_phase(2000, n);
        chk("reclear_cycles", n, 1024);
        zero_model();
        got_a = 32'hFFFF_FFFF; got_b = 32'hFFFF_FFFF;
        run_until_idle(10);
        drain();
        chk("reclear_read_a7", got_a, 32'h0);
        chk("reclear_read_b9", got_b, 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if (!ca.v && $urandom_range(0, 3) != 0)
                ca = mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
            if (!cb.v && $urandom_range(0, 3) != 0)
                cb = mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
            step();
        end
        run_until_idle(20);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
